// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: vsync-aligned timing-preset switcher that pulses the generator
// reset, waits for relock and acknowledges a 4-phase request handshake.
module video_mode_ctrl #(
    parameter int VS_POL      = 1,
    parameter int LOCK_FRAMES = 2,
    parameter int VS_TIMEOUT  = 4194303
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_req,
    input  logic [1:0]  I_req_preset,
    input  logic [2:0]  I_req_pattern,
    input  logic        I_vs,
    output logic        O_ack,
    output logic        O_busy,
    output logic [11:0] O_h_total,
    output logic [11:0] O_h_sync,
    output logic [11:0] O_h_bporch,
    output logic [11:0] O_h_res,
    output logic [11:0] O_v_total,
    output logic [11:0] O_v_sync,
    output logic [11:0] O_v_bporch,
    output logic [11:0] O_v_res,
    output logic [2:0]  O_mode,
    output logic [1:0]  O_cur_preset,
    output logic        O_gen_rst_n,
    output logic        O_locked,
    output logic        O_timeout,
    output logic [15:0] O_frame_cnt
);
    localparam logic        VS_ACT    = (VS_POL != 0);
    localparam logic [21:0] TMO_LAST  = 22'(VS_TIMEOUT - 1);
    localparam logic [3:0]  LOCK_LAST = 4'(LOCK_FRAMES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_APPLY, S_HOLD, S_RELOCK, S_ACK} state_t;

    // Packed {h_total,h_sync,h_bporch,h_res,v_total,v_sync,v_bporch,v_res}
    function automatic logic [95:0] f_preset(input logic [1:0] p);
        return (p == 2'd0) ? {12'd1056, 12'd128, 12'd88,  12'd800,  12'd628,  12'd4, 12'd23, 12'd600}  :
               (p == 2'd1) ? {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806,  12'd6, 12'd29, 12'd768}  :
               (p == 2'd2) ? {12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750,  12'd5, 12'd20, 12'd720}  :
                             {12'd2200, 12'd44,  12'd148, 12'd1920, 12'd1125, 12'd5, 12'd36, 12'd1080};
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        r_vs_d;
    logic [21:0] r_tmo;
    logic [1:0]  r_hold;
    logic [3:0]  r_edges;
    logic        r_boot;
    logic [1:0]  r_req_preset;
    logic [2:0]  r_req_pattern;
    logic [95:0] r_timing;
    logic [2:0]  r_mode;
    logic [1:0]  r_cur_preset;
    logic        r_gen_rst_n;
    logic        r_locked;
    logic        r_timeout;
    logic [15:0] r_frame_cnt;
    logic        r_ack;
    logic        r_busy;

    logic        w_vs_edge;
    logic        w_tmo;
    logic        w_tmo_hit;
    logic        w_lock;
    logic        w_gen_rst_n_d;
    logic        w_locked_d;
    logic        w_timeout_d;
    logic [15:0] w_frame_cnt_d;
    logic        w_ack_d;
    logic        w_busy_d;

    assign w_vs_edge = (I_vs == VS_ACT) && (r_vs_d != VS_ACT);
    assign w_tmo     = (r_tmo == TMO_LAST);
    assign w_tmo_hit = w_tmo && !w_vs_edge && (r_state == S_WAIT_VS || r_state == S_RELOCK);
    assign w_lock    = (r_state == S_RELOCK) && w_vs_edge && (r_edges == LOCK_LAST);

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state <= S_HOLD;
        end else begin
            r_state <= w_next;
        end
    end

    // The boot pass through RELOCK returns straight to IDLE without acknowledging.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = I_req ? S_WAIT_VS : S_IDLE;
            S_WAIT_VS: w_next = (w_vs_edge || w_tmo) ? S_APPLY : S_WAIT_VS;
            S_APPLY:   w_next = S_HOLD;
            S_HOLD:    w_next = (r_hold == 2'd3) ? S_RELOCK : S_HOLD;
            S_RELOCK:  w_next = (w_lock || w_tmo_hit) ? (r_boot ? S_IDLE : S_ACK) : S_RELOCK;
            S_ACK:     w_next = I_req ? S_ACK : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_gen_rst_n_d = (r_state == S_APPLY) ? 1'b0 :
                        (r_state == S_HOLD && w_next == S_RELOCK) ? 1'b1 : r_gen_rst_n;
        w_locked_d    = (r_state == S_APPLY) ? 1'b0 : w_lock ? 1'b1 : r_locked;
        w_frame_cnt_d = (r_state == S_APPLY) ? 16'd0 :
                        (w_vs_edge && r_locked) ? r_frame_cnt + 16'd1 : r_frame_cnt;
        w_timeout_d   = (r_state == S_IDLE && I_req) ? 1'b0 : w_tmo_hit ? 1'b1 : r_timeout;
        w_ack_d       = (w_next == S_ACK);
        w_busy_d      = (w_next != S_IDLE);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_d  <= !VS_ACT;
            r_tmo   <= '0;
            r_hold  <= '0;
            r_edges <= '0;
            r_boot  <= 1'b1;
        end else begin
            r_vs_d  <= I_vs;
            r_tmo   <= (w_vs_edge || w_next != r_state) ? 22'd0 : r_tmo + 22'd1;
            r_hold  <= (r_state == S_HOLD) ? r_hold + 2'd1 : 2'd0;
            r_edges <= (r_state == S_APPLY) ? 4'd0 :
                       (r_state == S_RELOCK && w_vs_edge) ? r_edges + 4'd1 : r_edges;
            r_boot  <= (r_state == S_RELOCK && w_next != S_RELOCK) ? 1'b0 : r_boot;
        end
    end

    // Request fields are captured only when accepted in IDLE; later changes are ignored.
    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_req_preset  <= 2'd2;
            r_req_pattern <= 3'd0;
        end else if (r_state == S_IDLE && I_req) begin
            r_req_preset  <= I_req_preset;
            r_req_pattern <= I_req_pattern;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_timing     <= f_preset(2'd2);
            r_mode       <= 3'd0;
            r_cur_preset <= 2'd2;
        end else if (r_state == S_APPLY) begin
            r_timing     <= f_preset(r_req_preset);
            r_mode       <= r_req_pattern;
            r_cur_preset <= r_req_preset;
        end
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_gen_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_timeout   <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            r_gen_rst_n <= w_gen_rst_n_d;
            r_locked    <= w_locked_d;
            r_timeout   <= w_timeout_d;
            r_frame_cnt <= w_frame_cnt_d;
            r_ack       <= w_ack_d;
            r_busy      <= w_busy_d;
        end
    end

    assign {O_h_total, O_h_sync, O_h_bporch, O_h_res,
            O_v_total, O_v_sync, O_v_bporch, O_v_res} = r_timing;
    assign O_mode       = r_mode;
    assign O_cur_preset = r_cur_preset;
    assign O_gen_rst_n  = r_gen_rst_n;
    assign O_locked     = r_locked;
    assign O_timeout    = r_timeout;
    assign O_frame_cnt  = r_frame_cnt;
    assign O_ack        = r_ack;
    assign O_busy       = r_busy;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: randomized directed bench; expectations come from the preset
// table and cycle arithmetic on the vsync edges the bench itself generates.
module tb_video_mode_ctrl;
    localparam int TMO = 300;

    logic        I_pxl_clk = 1'b0;
    logic        I_rst_n = 1'b0;
    logic        I_req = 1'b0;
    logic [1:0]  I_req_preset = 2'd0;
    logic [2:0]  I_req_pattern = 3'd0;
    logic        I_vs = 1'b0;
    logic        O_ack, O_busy, O_gen_rst_n, O_locked, O_timeout;
    logic [11:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
    logic [11:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
    logic [2:0]  O_mode;
    logic [1:0]  O_cur_preset;
    logic [15:0] O_frame_cnt;
    logic [95:0] w_obs;

    int          tests = 0;
    int          fails = 0;
    int          hi_left = 0;
    bit          ack_seen;
    logic [11:0] tbl[4][8];
    logic [95:0] cur_row;
    logic [2:0]  cur_mode;
    logic [1:0]  cur_p;
    logic [15:0] exp_fc;

    video_mode_ctrl #(.VS_POL(1), .LOCK_FRAMES(2), .VS_TIMEOUT(TMO)) dut (
        .I_pxl_clk(I_pxl_clk), .I_rst_n(I_rst_n), .I_req(I_req),
        .I_req_preset(I_req_preset), .I_req_pattern(I_req_pattern), .I_vs(I_vs),
        .O_ack(O_ack), .O_busy(O_busy),
        .O_h_total(O_h_total), .O_h_sync(O_h_sync), .O_h_bporch(O_h_bporch), .O_h_res(O_h_res),
        .O_v_total(O_v_total), .O_v_sync(O_v_sync), .O_v_bporch(O_v_bporch), .O_v_res(O_v_res),
        .O_mode(O_mode), .O_cur_preset(O_cur_preset), .O_gen_rst_n(O_gen_rst_n),
        .O_locked(O_locked), .O_timeout(O_timeout), .O_frame_cnt(O_frame_cnt)
    );

    assign w_obs = {O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res};

    always #5 I_pxl_clk = ~I_pxl_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [95:0] row(input logic [1:0] p);
        return {tbl[p][0], tbl[p][1], tbl[p][2], tbl[p][3], tbl[p][4], tbl[p][5], tbl[p][6], tbl[p][7]};
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive point is 1 time unit after each rising edge; vs pulses drop after hi_left extra cycles.
    task automatic tick();
        @(posedge I_pxl_clk);
        #1;
        ack_seen |= O_ack;
        if (hi_left > 0) hi_left--;
        else I_vs = 1'b0;
    endtask

    task automatic vs_edge(input int gap);
        repeat (gap) tick();
        I_vs = 1'b1;
        hi_left = $urandom_range(0, 2);
        tick();
    endtask

    task automatic expect_reset_vals(input string tag);
        check({tag, "_timing"}, w_obs, row(2'd2));
        check({tag, "_mode_preset"}, {O_mode, O_cur_preset}, {3'd0, 2'd2});
        check({tag, "_flags"}, {O_gen_rst_n, O_ack, O_locked, O_timeout, O_busy}, 5'b00001);
        check({tag, "_frame_cnt"}, O_frame_cnt, 16'd0);
    endtask

    task automatic do_boot();
        int n;
        ack_seen = 0;
        I_rst_n = 1'b1;
        n = 0;
        while (!O_gen_rst_n && n < 20) begin
            tick();
            n++;
        end
        check("boot_genrst_delay", n, 4);
        vs_edge($urandom_range(5, 150));
        check("boot_edge1", {O_locked, O_busy}, 2'b01);
        vs_edge($urandom_range(5, 150));
        check("boot_edge2", {O_locked, O_busy, O_ack}, 3'b100);
        repeat (5) tick();
        check("boot_ack_never", ack_seen, 0);
        cur_row = row(2'd2); cur_mode = 3'd0; cur_p = 2'd2; exp_fc = 16'd0;
        check("boot_cfg", {w_obs, O_mode, O_cur_preset}, {cur_row, cur_mode, cur_p});
    endtask

    task automatic do_switch(input logic [1:0] p, input logic [2:0] m);
        int  n;
        bit  same;
        I_req = 1'b1; I_req_preset = p; I_req_pattern = m;
        tick();
        check("sw_accept", {O_busy, O_timeout}, 2'b10);
        I_req_preset = 2'($urandom); I_req_pattern = 3'($urandom);
        same = 1;
        repeat ($urandom_range(5, 60)) begin
            tick();
            same &= (w_obs === cur_row) && ({O_mode, O_cur_preset} === {cur_mode, cur_p}) && O_gen_rst_n;
        end
        vs_edge(0);
        same &= (w_obs === cur_row) && ({O_mode, O_cur_preset} === {cur_mode, cur_p});
        check("sw_cfg_held", same, 1);
        tick();
        cur_row = row(p); cur_mode = m; cur_p = p; exp_fc = 16'd0;
        check("sw_timing", w_obs, cur_row);
        check("sw_mode", {O_mode, O_cur_preset}, {m, p});
        check("sw_apply", {O_gen_rst_n, O_locked, O_frame_cnt}, 18'd0);
        n = 0;
        while (!O_gen_rst_n && n < 20) begin
            n++;
            tick();
        end
        check("sw_genrst_low", n, 4);
        I_req_preset = p ^ 2'd1;
        vs_edge($urandom_range(5, 120));
        check("sw_relock1", {O_locked, O_ack}, 2'b00);
        vs_edge($urandom_range(5, 120));
        check("sw_relock2", {O_locked, O_ack, O_busy}, 3'b111);
        repeat ($urandom_range(1, 10)) tick();
        check("sw_ack_hold", {O_ack, O_cur_preset}, {1'b1, p});
        I_req = 1'b0;
        tick();
        check("sw_done", {O_ack, O_busy, O_cur_preset, O_mode}, {1'b0, 1'b0, p, m});
    endtask

    task automatic do_frames(input int k);
        repeat (k) begin
            vs_edge($urandom_range(5, 200));
            exp_fc++;
            check("frame_cnt", O_frame_cnt, exp_fc);
        end
    endtask

    task automatic do_timeout(input logic [1:0] p, input logic [2:0] m);
        int n;
        I_req = 1'b1; I_req_preset = p; I_req_pattern = m;
        tick();
        n = 0;
        while (!O_timeout && n < TMO + 50) begin
            tick();
            n++;
        end
        check("tmo_wait_cycles", n, TMO);
        check("tmo_cfg_held", {w_obs, O_cur_preset}, {cur_row, cur_p});
        tick();
        cur_row = row(p); cur_mode = m; cur_p = p;
        check("tmo_apply", {w_obs, O_mode, O_gen_rst_n}, {cur_row, m, 1'b0});
        n = 0;
        while (!O_gen_rst_n && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!O_ack && n < TMO + 50) begin
            tick();
            n++;
        end
        check("tmo_relock_cycles", n, TMO);
        check("tmo_flags", {O_locked, O_timeout}, 2'b01);
        I_req = 1'b0;
        tick();
        check("tmo_done", {O_ack, O_busy, O_timeout}, 3'b001);
    endtask

    initial begin
        tbl[0] = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628,  12'd4, 12'd23, 12'd600};
        tbl[1] = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806,  12'd6, 12'd29, 12'd768};
        tbl[2] = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750,  12'd5, 12'd20, 12'd720};
        tbl[3] = '{12'd2200, 12'd44,  12'd148, 12'd1920, 12'd1125, 12'd5, 12'd36, 12'd1080};
        repeat (3) tick();
        expect_reset_vals("rst");
        do_boot();
        do_switch(2'd3, 3'd1);
        do_frames(3);
        repeat (2) begin
            do_switch(2'($urandom), 3'($urandom));
            do_frames($urandom_range(1, 4));
        end
        tick();
        force dut.r_frame_cnt = 16'hFFFD;
        tick();
        release dut.r_frame_cnt;
        exp_fc = 16'hFFFD;
        tick();
        check("wrap_preload", O_frame_cnt, exp_fc);
        do_frames(4);
        do_timeout(2'($urandom), 3'($urandom));
        I_req = 1'b1; I_req_preset = 2'd1; I_req_pattern = 3'd5;
        tick();
        vs_edge(10);
        tick();
        check("mid_applied", w_obs, row(2'd1));
        tick();
        #2;
        I_rst_n = 1'b0;
        I_req = 1'b0;
        #1;
        expect_reset_vals("mid_rst");
        repeat (3) tick();
        do_boot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
